// File: rtl/codec_cfg_pkg.sv
// Shared types for the codec init sequencer: FSM encoding, register table word, device address.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POWERUP   = 3'd1,
    ST_LOAD      = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } reg_entry_t;

  // 7-bit I2C address of the codec, forwarded to the I2C master with every write
  localparam logic [6:0] CODEC_DEV_ADDR = 7'h18;

  // wide enough for the power-up and timeout counts
  localparam int CNT_W = 20;

  function automatic logic is_busy(input state_t s);
    return (s == ST_POWERUP) || (s == ST_LOAD) || (s == ST_ISSUE) ||
           (s == ST_WAIT_RESP) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/codec_init_sequencer_if.sv
// Write request channel between the init sequencer (master) and the I2C master (slave).
interface codec_init_sequencer_if;
  logic        i2c_req;
  logic [15:0] i2c_reg_addr;
  logic [7:0]  i2c_data;
  logic [6:0]  i2c_dev_addr;
  logic        i2c_ack;
  logic        i2c_nack;

  modport master (output i2c_req, i2c_reg_addr, i2c_data, i2c_dev_addr,
                  input  i2c_ack, i2c_nack);
  modport slave  (input  i2c_req, i2c_reg_addr, i2c_data, i2c_dev_addr,
                  output i2c_ack, i2c_nack);
endinterface

// File: rtl/codec_reg_rom.sv
// Codec register table: clock/PLL, serial port, DAC/mixer, playback power.
// Purely combinational lookup, no handshake.
module codec_reg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  idx,
  output reg_entry_t  word
);

  always_comb begin
    word = '0;
    case (idx)
      4'd0:  word = {16'h0004, 8'h03};  // clock mux: PLL as codec clock
      4'd1:  word = {16'h0005, 8'h91};  // PLL P/R, power up
      4'd2:  word = {16'h0006, 8'h08};  // PLL J
      4'd3:  word = {16'h0007, 8'h00};  // PLL D msb
      4'd4:  word = {16'h0008, 8'h00};  // PLL D lsb
      4'd5:  word = {16'h000B, 8'h82};  // NDAC
      4'd6:  word = {16'h000C, 8'h87};  // MDAC
      4'd7:  word = {16'h001B, 8'h00};  // serial port: I2S, 16 bit
      4'd8:  word = {16'h003C, 8'h08};  // DAC processing block
      4'd9:  word = {16'h0040, 8'h00};  // DAC unmute
      4'd10: word = {16'h0041, 8'h00};  // DAC volume 0 dB
      4'd11: word = {16'h003F, 8'hD4};  // DAC channel power up
      4'd12: word = {16'h0123, 8'h44};  // mixer routing
      4'd13: word = {16'h0128, 8'h06};  // headphone driver gain
      4'd14: word = {16'h0120, 8'h86};  // playback power
      4'd15: word = {16'h0000, 8'h00};  // back to page 0
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec register table after reset/start and issues each write to the I2C master.
// Per entry: LOAD + ISSUE + response wait + GAP_CYCLES; waits on ack/nack with a timeout.
// Optional CODEC_RETRY_EN: re-issue a nacked entry up to MAX_RETRY times before aborting.
module codec_init_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int NUM_REGS       = 12,
  parameter int POWERUP_CYCLES = 1000,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 3
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  codec_init_sequencer_if.master i2c,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   stream_en,
  output logic [3:0]             entry_idx
);

  if (NUM_REGS > 16 || MAX_RETRY > 3) begin : g_cfg_check
    $error("codec_init_sequencer: NUM_REGS must be <= 16 and MAX_RETRY <= 3");
  end

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_REGS - 1);
  localparam state_t           AFTER_RESP = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  reg_entry_t       rom_word, word_q;
  logic             req;
  logic             idx_clr, idx_inc, ld_word;
`ifdef CODEC_RETRY_EN
  logic [1:0]       retry;
  logic             retry_inc;
`endif

  codec_reg_rom u_rom (
    .idx  (entry_idx),
    .word (rom_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_POWERUP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    ld_word   = 1'b0;
`ifdef CODEC_RETRY_EN
    retry_inc = 1'b0;
`endif
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_nxt = ST_POWERUP;
      end
      ST_POWERUP: begin
        if (NUM_REGS == 0) begin
          state_nxt = ST_IDLE;
        end else if (cnt == PWR_LAST) begin
          state_nxt = ST_LOAD;
          idx_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        ld_word   = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        // nack wins over a coincident ack
        if (i2c.i2c_nack) begin
`ifdef CODEC_RETRY_EN
          if (retry < 2'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_nxt = AFTER_RESP;
          end else begin
            state_nxt = ST_ERROR;
          end
`else
          state_nxt = ST_ERROR;
`endif
        end else if (i2c.i2c_ack) begin
          if (entry_idx == IDX_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = AFTER_RESP;
          end
        end else if (cnt == TMO_LAST) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_ERROR;
    endcase
  end

  // One counter serves power-up, gap and response timeout: it restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      entry_idx <= '0;
      word_q    <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cnt <= (state_nxt != state || !is_busy(state)) ? '0 : cnt + 1'b1;
      if (idx_clr)      entry_idx <= '0;
      else if (idx_inc) entry_idx <= entry_idx + 1'b1;
      if (ld_word) word_q <= rom_word;
      req   <= (state_nxt == ST_WAIT_RESP);
      busy  <= is_busy(state_nxt);
      done  <= (state_nxt == ST_DONE) || (state_nxt == ST_IDLE);
      error <= (state_nxt == ST_ERROR);
    end
  end

`ifdef CODEC_RETRY_EN
  // cleared whenever a new entry is selected, so LOAD of a fresh entry starts at zero retries
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    retry <= '0;
    else if (idx_clr || idx_inc)  retry <= '0;
    else if (retry_inc)           retry <= retry + 1'b1;
  end
`endif

  assign stream_en        = done;
  assign i2c.i2c_req      = req;
  assign i2c.i2c_reg_addr = word_q.addr;
  assign i2c.i2c_data     = word_q.data;
  assign i2c.i2c_dev_addr = CODEC_DEV_ADDR;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Self-checking bench: table vectors, hand-written corner sequences, randomized responder vs timing model.
module tb_codec_init_sequencer;

  localparam int NREG = 4;
  localparam int PWR  = 10;
  localparam int GAP  = 2;
  localparam int TMO  = 20;
  localparam int MAXR = 3;
`ifdef CODEC_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam logic [1:0] K_ACK = 2'd0, K_NACK = 2'd1, K_BOTH = 2'd2, K_NONE = 2'd3;
  localparam int MAXP = 24;
  localparam int NONE_AT = 31;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, error, stream_en;
  logic [3:0] entry_idx;

  codec_init_sequencer_if bus ();

  codec_init_sequencer #(
    .NUM_REGS(NREG), .POWERUP_CYCLES(PWR), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .i2c(bus),
    .busy(busy), .done(done), .error(error), .stream_en(stream_en), .entry_idx(entry_idx)
  );

  always #5 clk = ~clk;

  // expected codec table words {addr, data} for the entries used here
  logic [23:0] rom_ref [NREG] = '{24'h000403, 24'h000591, 24'h000608, 24'h000700};

  typedef struct packed {
    logic [7:0][1:0] k;
    logic [7:0][3:0] d;
    logic [4:0]      start_at;
    logic            stray;
    logic [4:0]      exp_pulses;
    logic            exp_done;
    logic            exp_err;
    logic [3:0]      exp_idx;
  } vec_t;

  vec_t vecs [5];

  logic [1:0] plan_k [MAXP];
  int         plan_d [MAXP];
  int         start_at, abort_at;
  bit         stray_en, run_ok, aborted;

  int          obs_rise[$], obs_fall[$];
  logic [15:0] obs_addr[$];
  logic [7:0]  obs_data[$];
  int          exp_rise[$], exp_fall[$], exp_entry[$];
  bit          exp_done, exp_err;
  int          exp_idx;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.i2c_ack = 1'b0;
    bus.i2c_nack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Acts as the I2C master: answers each request according to the plan, records what it saw.
  task automatic run_seq();
    int cyc, np, hold, cur;
    bit req_q;
    obs_rise.delete(); obs_fall.delete(); obs_addr.delete(); obs_data.delete();
    cyc = 0; np = 0; hold = 0; cur = 0; req_q = 1'b0;
    run_ok = 1'b0; aborted = 1'b0;
    while (cyc < 3000) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      bus.i2c_ack = 1'b0; bus.i2c_nack = 1'b0; start = 1'b0;
      if (!bus.i2c_req && req_q) obs_fall.push_back(cyc);
      if (bus.i2c_req && !req_q) begin
        cur = np; np++;
        obs_rise.push_back(cyc);
        obs_addr.push_back(bus.i2c_reg_addr);
        obs_data.push_back(bus.i2c_data);
        hold = 0;
        if (cur == start_at) start = 1'b1;
        if (cur == abort_at) begin aborted = 1'b1; run_ok = 1'b1; break; end
      end
      req_q = bus.i2c_req;
      if (done || error) begin run_ok = 1'b1; break; end
      if (bus.i2c_req) begin
        hold++;
        if (cur < MAXP && hold == plan_d[cur]) begin
          bus.i2c_ack  = (plan_k[cur] == K_ACK) || (plan_k[cur] == K_BOTH);
          bus.i2c_nack = (plan_k[cur] == K_NACK) || (plan_k[cur] == K_BOTH);
        end
      end else if (stray_en) begin
        bus.i2c_ack = 1'b1;
      end
    end
    bus.i2c_ack = 1'b0; bus.i2c_nack = 1'b0; start = 1'b0;
    check("run_within_budget", 32'(run_ok), 32'd1);
  endtask

  // Timing model: req rises PWR+2 after reset/start, response after d cycles, next req GAP+2 later.
  task automatic model();
    int t, e, r, p, d;
    logic [1:0] k;
    exp_rise.delete(); exp_fall.delete(); exp_entry.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    t = PWR + 2; e = 0; r = 0; p = 0;
    while (p < 64) begin
      exp_rise.push_back(t);
      exp_entry.push_back(e);
      k = (p < MAXP) ? plan_k[p] : K_ACK;
      d = (p < MAXP) ? plan_d[p] : 1;
      p++;
      if (k == K_NONE) begin exp_fall.push_back(t + TMO); exp_err = 1'b1; break; end
      exp_fall.push_back(t + d);
      if (k == K_ACK) begin
        if (e == NREG - 1) begin exp_done = 1'b1; break; end
        e++; r = 0;
      end else if (RETRY && r < MAXR) begin
        r++;
      end else begin
        exp_err = 1'b1; break;
      end
      t = t + d + GAP + 2;
    end
    exp_idx = e;
  endtask

  task automatic compare_run(input string tag);
    check({tag, ".pulses"}, obs_rise.size(), exp_rise.size());
    for (int i = 0; i < exp_rise.size() && i < obs_rise.size(); i++) begin
      check($sformatf("%s.rise%0d", tag, i), obs_rise[i], exp_rise[i]);
      check($sformatf("%s.fall%0d", tag, i), (i < obs_fall.size()) ? obs_fall[i] : -1, exp_fall[i]);
      check($sformatf("%s.addr%0d", tag, i), obs_addr[i], rom_ref[exp_entry[i]][23:8]);
      check($sformatf("%s.data%0d", tag, i), obs_data[i], rom_ref[exp_entry[i]][7:0]);
    end
    check({tag, ".done"}, done, exp_done);
    check({tag, ".stream_en"}, stream_en, exp_done);
    check({tag, ".error"}, error, exp_err);
    check({tag, ".entry_idx"}, entry_idx, exp_idx);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".req"}, bus.i2c_req, 0);
  endtask

  task automatic plan_all_ack();
    for (int p = 0; p < MAXP; p++) begin plan_k[p] = K_ACK; plan_d[p] = 5; end
    start_at = NONE_AT; abort_at = NONE_AT; stray_en = 1'b0;
  endtask

  task automatic restart(input string tag);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".done_drop"}, done, 0);
    check({tag, ".error_drop"}, error, 0);
    check({tag, ".stream_drop"}, stream_en, 0);
    check({tag, ".busy_rise"}, busy, 1);
  endtask

  initial begin
    bus.i2c_ack = 1'b0;
    bus.i2c_nack = 1'b0;

    for (int v = 0; v < 5; v++) begin
      vecs[v] = '0;
      vecs[v].d = {8{4'd5}};
      vecs[v].start_at = 5'(NONE_AT);
    end
    // v0: plain power-up, start pulse during entry 1
    vecs[0].start_at = 5'd1;
    vecs[0].exp_pulses = 5'd4; vecs[0].exp_done = 1'b1; vecs[0].exp_idx = 4'd3;
    // v1: three nacks on entry 1
    vecs[1].k[1] = K_NACK; vecs[1].k[2] = K_NACK; vecs[1].k[3] = K_NACK; vecs[1].d = {8{4'd3}};
    // v2: no response on entry 2
    vecs[2].k[2] = K_NONE;
    vecs[2].exp_pulses = 5'd3; vecs[2].exp_err = 1'b1; vecs[2].exp_idx = 4'd2;
    // v3: ack+nack together on entry 0
    vecs[3].k[0] = K_BOTH; vecs[3].d[0] = 4'd1;
    // v4: four nacks on entry 3, stray acks between requests
    vecs[4].k[3] = K_NACK; vecs[4].k[4] = K_NACK; vecs[4].k[5] = K_NACK; vecs[4].k[6] = K_NACK;
    vecs[4].stray = 1'b1;
    if (RETRY) begin
      vecs[1].exp_pulses = 5'd7; vecs[1].exp_done = 1'b1; vecs[1].exp_idx = 4'd3;
      vecs[3].exp_pulses = 5'd5; vecs[3].exp_done = 1'b1; vecs[3].exp_idx = 4'd3;
      vecs[4].exp_pulses = 5'd7; vecs[4].exp_err  = 1'b1; vecs[4].exp_idx = 4'd3;
    end else begin
      vecs[1].exp_pulses = 5'd2; vecs[1].exp_err = 1'b1; vecs[1].exp_idx = 4'd1;
      vecs[3].exp_pulses = 5'd1; vecs[3].exp_err = 1'b1; vecs[3].exp_idx = 4'd0;
      vecs[4].exp_pulses = 5'd4; vecs[4].exp_err = 1'b1; vecs[4].exp_idx = 4'd3;
    end

    // reset state
    repeat (2) @(negedge clk);
    check("rst.req", bus.i2c_req, 0);
    check("rst.addr", bus.i2c_reg_addr, 0);
    check("rst.data", bus.i2c_data, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    check("rst.stream_en", stream_en, 0);
    check("rst.entry_idx", entry_idx, 0);
    check("dev_addr", bus.i2c_dev_addr, 32'h18);

    for (int v = 0; v < 5; v++) begin
      for (int p = 0; p < MAXP; p++) begin
        plan_k[p] = (p < 8) ? vecs[v].k[p] : K_ACK;
        plan_d[p] = (p < 8) ? int'(vecs[v].d[p]) : 5;
      end
      start_at = int'(vecs[v].start_at);
      abort_at = NONE_AT;
      stray_en = vecs[v].stray;
      do_reset();
      run_seq();
      model();
      compare_run($sformatf("vec%0d", v));
      check($sformatf("vec%0d.tbl_pulses", v), obs_rise.size(), vecs[v].exp_pulses);
      check($sformatf("vec%0d.tbl_done", v), done, vecs[v].exp_done);
      check($sformatf("vec%0d.tbl_error", v), error, vecs[v].exp_err);
      check($sformatf("vec%0d.tbl_idx", v), entry_idx, vecs[v].exp_idx);
      if (v == 0) begin
        check("vec0.first_req_cycle", obs_rise[0], 12);
        restart("restart_done");
        plan_all_ack();
        run_seq(); model(); compare_run("rerun_done");
      end
      if (v == 2) begin
        check("vec2.timeout_len", (obs_fall.size() > 2) ? obs_fall[2] - obs_rise[2] : -1, TMO);
        restart("restart_err");
        plan_all_ack();
        run_seq(); model(); compare_run("rerun_err");
      end
    end

    // asynchronous reset while entry 3 is on the bus
    plan_all_ack();
    abort_at = 3;
    do_reset();
    run_seq();
    check("abort.reached", 32'(aborted), 32'd1);
    check("abort.pre_req", bus.i2c_req, 1);
    check("abort.pre_idx", entry_idx, 3);
    #1 reset = 1'b1;
    #1;
    check("abort.req", bus.i2c_req, 0);
    check("abort.busy", busy, 0);
    check("abort.idx", entry_idx, 0);
    check("abort.addr", bus.i2c_reg_addr, 0);
    check("abort.data", bus.i2c_data, 0);
    plan_all_ack();
    do_reset();
    run_seq(); model(); compare_run("after_abort");

    // randomized responder
    for (int it = 0; it < 12; it++) begin
      for (int p = 0; p < MAXP; p++) begin
        int r;
        r = $urandom_range(0, 99);
        plan_k[p] = (r < 75) ? K_ACK : (r < 87) ? K_NACK : (r < 94) ? K_BOTH : K_NONE;
        plan_d[p] = $urandom_range(1, 8);
      end
      start_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : NONE_AT;
      abort_at = NONE_AT;
      stray_en = ($urandom_range(0, 1) == 1);
      do_reset();
      run_seq(); model(); compare_run($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
